// File: rtl/seg7_if.sv
// Bus between score/game logic and the multiplexed seven-segment driver:
// digit data and display controls in, anode/cathode pins and frame pulse out.
interface seg7_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bin;
  logic [NUM_DIGITS-1:0]   dot;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    load;
  logic                    lz_suppress;
  logic [3:0]              bright;
  logic [NUM_DIGITS-1:0]   seg_select;
  logic [7:0]              hex;
  logic                    frame;

  modport master (
    output bin, dot, blank, load, lz_suppress, bright,
    input  seg_select, hex, frame
  );

  modport slave (
    input  bin, dot, blank, load, lz_suppress, bright,
    output seg_select, hex, frame
  );
endinterface

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous loading,
// leading-zero suppression, per-digit blank/dot and PWM brightness.
module seg7_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic  CLK,
  input  logic  RESET_N,
  seg7_if.slave bus
);

  localparam int                DW        = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]  SLOT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]     DIGIT_MAX = DW'(NUM_DIGITS - 1);

  // Scan timing
  logic [CNT_W-1:0] slot_cnt;
  logic [DW-1:0]    digit;
  logic [3:0]       pwm_cnt;
  logic             frame_q;

  // Shadow (written any time) and active (changed only at frame boundary) copies
  logic [4*NUM_DIGITS-1:0] shadow_bin, act_bin;
  logic [NUM_DIGITS-1:0]   shadow_dot, act_dot;
  logic [NUM_DIGITS-1:0]   shadow_blank, act_blank;
  logic                    pending;
  logic                    live;

  logic [NUM_DIGITS-1:0] seg_q;
  logic [7:0]            hex_q;

  logic slot_last, frame_edge;

  assign slot_last  = (slot_cnt == SLOT_MAX);
  assign frame_edge = slot_last && (digit == DIGIT_MAX);

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_font = 7'b1000000;
      4'h1:    seg_font = 7'b1111001;
      4'h2:    seg_font = 7'b0100100;
      4'h3:    seg_font = 7'b0110000;
      4'h4:    seg_font = 7'b0011001;
      4'h5:    seg_font = 7'b0010010;
      4'h6:    seg_font = 7'b0000010;
      4'h7:    seg_font = 7'b1111000;
      4'h8:    seg_font = 7'b0000000;
      4'h9:    seg_font = 7'b0010000;
      4'hA:    seg_font = 7'b0001000;
      4'hB:    seg_font = 7'b0000011;
      4'hC:    seg_font = 7'b1000110;
      4'hD:    seg_font = 7'b0100001;
      4'hE:    seg_font = 7'b0000110;
      default: seg_font = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_cnt <= '0;
      digit    <= '0;
      pwm_cnt  <= '0;
      frame_q  <= 1'b0;
    end else begin
      // NOTE: state registers use <= so every flop samples pre-edge values;
      // blocking here would make later statements see already-updated state.
      slot_cnt <= slot_last ? '0 : slot_cnt + CNT_W'(1);
      if (slot_last)
        digit <= (digit == DIGIT_MAX) ? '0 : digit + DW'(1);
      pwm_cnt <= pwm_cnt + 4'd1;
      frame_q <= frame_edge;
    end
  end

  // NOTE: shadow/active are a handful of flops, not a RAM, so they take the
  // async reset like everything else and the display starts from a known state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow_bin   <= '0;
      shadow_dot   <= '0;
      shadow_blank <= '0;
      act_bin      <= '0;
      act_dot      <= '0;
      act_blank    <= '0;
      pending      <= 1'b0;
      live         <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_bin   <= bus.bin;
        shadow_dot   <= bus.dot;
        shadow_blank <= bus.blank;
      end
      if (frame_edge) begin
        // A strobe landing on the boundary cycle bypasses the shadow copy
        if (bus.load) begin
          act_bin   <= bus.bin;
          act_dot   <= bus.dot;
          act_blank <= bus.blank;
          live      <= 1'b1;
        end else if (pending) begin
          act_bin   <= shadow_bin;
          act_dot   <= shadow_dot;
          act_blank <= shadow_blank;
          live      <= 1'b1;
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  // upper_zero[d]: active nibbles d..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            cur_nib;
  logic                  suppress;
  logic [7:0]            hex_d;
  logic [NUM_DIGITS-1:0] seg_d;

  always_comb begin
    logic run;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    upper_zero = '0;
    run        = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      run           = run & (act_bin[4*d +: 4] == 4'd0);
      upper_zero[d] = run;
    end
  end

  always_comb begin
    cur_nib  = act_bin[int'(digit)*4 +: 4];
    suppress = bus.lz_suppress && (digit != '0) && upper_zero[digit];

    hex_d = 8'hFF;
    if (live && !act_blank[digit]) begin
      hex_d[7]   = ~act_dot[digit];
      hex_d[6:0] = suppress ? 7'h7F : seg_font(cur_nib);
    end

    // Slot position 0 is a dead cycle so the outgoing digit never ghosts
    seg_d = '1;
    if (live && (slot_cnt != '0) && (pwm_cnt <= bus.bright))
      seg_d[digit] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seg_q <= '1;
      hex_q <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      hex_q <= hex_d;
    end
  end

  assign bus.seg_select = seg_q;
  assign bus.hex        = hex_q;
  assign bus.frame      = frame_q;

endmodule
